fir_controller: RTL and testbench

FIR_CONTROLLER -- requirements
Module: fir_controller

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_controller.sv | 122 ++++++++++++
 tb/tb_fir_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared datapath encodings for the FIR sequencer: ALU opcodes and the
// register-file layout the controller addresses.
package fir_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_COPY  = 3'd1;
   localparam logic [2:0] OP_LOAD1 = 3'd2;
   localparam logic [2:0] OP_LOAD2 = 3'd3;
   localparam logic [2:0] OP_ADD   = 3'd4;
   localparam logic [2:0] OP_SUB   = 3'd5;
   localparam logic [2:0] OP_MUL   = 3'd6;

   localparam logic [3:0] R_RES  = 4'd0;
   localparam logic [3:0] R_S1   = 4'd1;
   localparam logic [3:0] R_S2   = 4'd2;
   localparam logic [3:0] R_S3   = 4'd3;
   localparam logic [3:0] R_S4   = 4'd4;
   localparam logic [3:0] R_IN   = 4'd5;
   localparam logic [3:0] R_F0   = 4'd6;
   localparam logic [3:0] R_F1   = 4'd7;
   localparam logic [3:0] R_F2   = 4'd8;
   localparam logic [3:0] R_F3   = 4'd9;
   localparam logic [3:0] R_PROD = 4'd10;

   function automatic logic [3:0] coef_reg(input logic [1:0] idx);
      return R_F0 + {2'b00, idx};
   endfunction

endpackage

// File: rtl/fir_controller.sv
// FIR sequencer: loads coefficients, shifts in samples and drives the
// 4-tap multiply/accumulate chain (+F0 -F1 +F2 -F3) one datapath op per cycle.
module fir_controller
   import fir_pkg::*;
(
   input  logic       clk,
   input  logic       n_reset,
   input  logic       dr,
   input  logic       lc,
   input  logic [1:0] coefficient_num,
   input  logic       overflow,
   output logic       modwait,
   output logic       cnt_up,
   output logic       clear,
   output logic       err,
   output logic [2:0] op,
   output logic [3:0] src1,
   output logic [3:0] src2,
   output logic [3:0] dest
);

   typedef enum logic [4:0] {
      IDLE, LOADC, STORE, ZERO,
      SORT1, SORT2, SORT3, SORT4,
      MUL1, ADD1, MUL2, SUB1, MUL3, ADD2, MUL4, SUB2,
      EIDLE
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] cidx_q, cidx_d;
   logic       modwait_q, modwait_d;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         cidx_q    <= 2'd0;
         modwait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cidx_q    <= cidx_d;
         modwait_q <= modwait_d;
      end
   end

   assign modwait = modwait_q;

   always_comb begin
      state_d = state_q;
      cidx_d  = cidx_q;
      case (state_q)
         IDLE, EIDLE: begin
            if (dr) begin
               state_d = STORE;
            end else if (lc) begin
               state_d = LOADC;
               cidx_d  = coefficient_num;
            end
         end
         LOADC: state_d = IDLE;
         STORE: state_d = dr ? ZERO : EIDLE;
         ZERO:  state_d = SORT1;
         SORT1: state_d = SORT2;
         SORT2: state_d = SORT3;
         SORT3: state_d = SORT4;
         SORT4: state_d = MUL1;
         MUL1:  state_d = ADD1;
         ADD1:  state_d = overflow ? EIDLE : MUL2;
         MUL2:  state_d = SUB1;
         SUB1:  state_d = overflow ? EIDLE : MUL3;
         MUL3:  state_d = ADD2;
         ADD2:  state_d = overflow ? EIDLE : MUL4;
         MUL4:  state_d = SUB2;
         SUB2:  state_d = overflow ? EIDLE : IDLE;
         default: state_d = IDLE;
      endcase
      // Registered busy flag tracks the state being entered.
      modwait_d = !((state_d == IDLE) || (state_d == EIDLE));
   end

   always_comb begin
      op     = OP_NOP;
      src1   = 4'd0;
      src2   = 4'd0;
      dest   = 4'd0;
      cnt_up = 1'b0;
      clear  = 1'b0;
      err    = 1'b0;
      case (state_q)
         LOADC: begin
            op    = OP_LOAD2;
            dest  = coef_reg(cidx_q);
            clear = (cidx_q == 2'd0);
         end
         STORE: begin
            op   = OP_LOAD1;
            dest = R_IN;
         end
         ZERO: begin
            op     = OP_SUB;
            src1   = R_RES;
            src2   = R_RES;
            dest   = R_RES;
            cnt_up = 1'b1;
         end
         SORT1: begin op = OP_COPY; src1 = R_S2; dest = R_S1; end
         SORT2: begin op = OP_COPY; src1 = R_S3; dest = R_S2; end
         SORT3: begin op = OP_COPY; src1 = R_S4; dest = R_S3; end
         SORT4: begin op = OP_COPY; src1 = R_IN; dest = R_S4; end
         MUL1:  begin op = OP_MUL; src1 = R_S1; src2 = R_F0; dest = R_PROD; end
         ADD1:  begin op = OP_ADD; src1 = R_RES; src2 = R_PROD; dest = R_RES; end
         MUL2:  begin op = OP_MUL; src1 = R_S2; src2 = R_F1; dest = R_PROD; end
         SUB1:  begin op = OP_SUB; src1 = R_RES; src2 = R_PROD; dest = R_RES; end
         MUL3:  begin op = OP_MUL; src1 = R_S3; src2 = R_F2; dest = R_PROD; end
         ADD2:  begin op = OP_ADD; src1 = R_RES; src2 = R_PROD; dest = R_RES; end
         MUL4:  begin op = OP_MUL; src1 = R_S4; src2 = R_F3; dest = R_PROD; end
         SUB2:  begin op = OP_SUB; src1 = R_RES; src2 = R_PROD; dest = R_RES; end
         EIDLE: err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fir_controller.sv
// Bench for fir_controller: directed scenarios then random traffic, all checked
// against a position-in-sequence model of the sample/coefficient protocol.
module tb_fir_controller;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       dr = 1'b0;
   logic       lc = 1'b0;
   logic       overflow = 1'b0;
   logic [1:0] coefficient_num = 2'd0;
   logic       modwait, cnt_up, clear, err;
   logic [2:0] op;
   logic [3:0] src1, src2, dest;

   int checks = 0;
   int failures = 0;
   int cnt_seen = 0;

   // Model position: -1 idle, -2 error idle, -3 coefficient load, 0..13 sample chain.
   localparam int IDLE_P  = -1;
   localparam int EIDLE_P = -2;
   localparam int LOADC_P = -3;
   int         m_pos = IDLE_P;
   logic [1:0] m_idx = 2'd0;

   int op_t [14] = '{2, 5, 1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
   int s1_t [14] = '{0, 0, 2, 3, 4, 5, 1, 0, 2, 0, 3, 0, 4, 0};
   int s2_t [14] = '{0, 0, 0, 0, 0, 0, 6, 10, 7, 10, 8, 10, 9, 10};
   int ds_t [14] = '{5, 0, 1, 2, 3, 4, 10, 0, 10, 0, 10, 0, 10, 0};

   fir_controller dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .dr             (dr),
      .lc             (lc),
      .coefficient_num(coefficient_num),
      .overflow       (overflow),
      .modwait        (modwait),
      .cnt_up         (cnt_up),
      .clear          (clear),
      .err            (err),
      .op             (op),
      .src1           (src1),
      .src2           (src2),
      .dest           (dest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d model_pos=%0d", tag, got, exp, m_pos);
      end
   endtask

   task automatic check_outputs();
      logic [2:0] eop;
      logic [3:0] es1, es2, ed;
      logic       ecu, ecl, eer, emw;
      eop = 3'd0; es1 = 4'd0; es2 = 4'd0; ed = 4'd0;
      ecu = 1'b0; ecl = 1'b0; eer = 1'b0;
      if (m_pos == LOADC_P) begin
         eop = 3'd3;
         ed  = 4'd6 + {2'b00, m_idx};
         ecl = (m_idx == 2'd0);
      end else if (m_pos == EIDLE_P) begin
         eer = 1'b1;
      end else if (m_pos >= 0) begin
         eop = 3'(op_t[m_pos]);
         es1 = 4'(s1_t[m_pos]);
         es2 = 4'(s2_t[m_pos]);
         ed  = 4'(ds_t[m_pos]);
         ecu = (m_pos == 1);
      end
      emw = (m_pos == LOADC_P) || (m_pos >= 0);
      chk("op", {1'b0, op}, {1'b0, eop});
      chk("src1", src1, es1);
      chk("src2", src2, es2);
      chk("dest", dest, ed);
      chk("cnt_up", {3'b0, cnt_up}, {3'b0, ecu});
      chk("clear", {3'b0, clear}, {3'b0, ecl});
      chk("err", {3'b0, err}, {3'b0, eer});
      chk("modwait", {3'b0, modwait}, {3'b0, emw});
   endtask

   task automatic model_step(input logic d, input logic l, input logic [1:0] c, input logic o);
      if (m_pos == IDLE_P || m_pos == EIDLE_P) begin
         if (d) m_pos = 0;
         else if (l) begin
            m_pos = LOADC_P;
            m_idx = c;
         end
      end else if (m_pos == LOADC_P) m_pos = IDLE_P;
      else if (m_pos == 0) m_pos = d ? 1 : EIDLE_P;
      else if (o && (m_pos == 7 || m_pos == 9 || m_pos == 11 || m_pos == 13)) m_pos = EIDLE_P;
      else if (m_pos == 13) m_pos = IDLE_P;
      else m_pos++;
   endtask

   // Entered and left at a falling edge; outputs checked before the rising edge.
   task automatic cyc(input logic d, input logic l, input logic [1:0] c, input logic o);
      dr = d; lc = l; coefficient_num = c; overflow = o;
      #1 check_outputs();
      if (cnt_up === 1'b1) cnt_seen++;
      @(posedge clk);
      model_step(d, l, c, o);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic rd, rl, ro;
      logic [1:0] rc;

      #1 check_outputs();
      @(negedge clk);
      n_reset = 1'b1;

      // coefficient loads, index 2 then index 0 (clear)
      cyc(0, 1, 2'd2, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 1, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);

      // full sample with dr held
      cnt_seen = 0;
      repeat (15) cyc(1, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      chk("cnt_once", 4'(cnt_seen), 4'd1);

      // overflow during SUB1, then recover via dr
      for (int i = 0; i < 20 && m_pos != EIDLE_P; i++) cyc(1, 0, 2'd0, m_pos == 9);
      cyc(0, 0, 2'd0, 0);
      cyc(1, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 1, 2'd1, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);

      // dr for one cycle only
      cnt_seen = 0;
      cyc(1, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);
      chk("no_cnt_drop", 4'(cnt_seen), 4'd0);

      // leave EIDLE via a load, then dr/lc collision in IDLE
      cyc(0, 1, 2'd1, 0);
      cyc(0, 0, 2'd0, 0);
      cyc(1, 1, 2'd3, 0);
      repeat (14) cyc(1, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0);

      // async reset in the middle of MUL2
      for (int i = 0; i < 20 && m_pos != 8; i++) cyc(1, 0, 2'd0, 0);
      dr = 1'b0;
      #2 n_reset = 1'b0;
      #1 m_pos = IDLE_P;
      m_idx = 2'd0;
      check_outputs();
      @(negedge clk);
      check_outputs();
      n_reset = 1'b1;
      cnt_seen = 0;
      repeat (3) cyc(0, 0, 2'd0, 0);
      chk("no_cnt_after_rst", 4'(cnt_seen), 4'd0);
      cyc(0, 1, 2'd3, 0);
      cyc(0, 0, 2'd0, 0);

      // random traffic
      repeat (400) begin
         rd = ($urandom_range(0, 3) != 0);
         rl = ($urandom_range(0, 2) == 0);
         rc = 2'($urandom_range(0, 3));
         ro = ($urandom_range(0, 7) == 0);
         cyc(rd, rl, rc, ro);
      end
      repeat (16) cyc(0, 0, 2'd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
